stall_ctrl: RTL and testbench



---
 rtl/stall_ctrl.sv | 109 ++++++++++
 tb/tb_stall_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - D-stage hazard detection, stall/bubble control, forward selects and stall counter
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   d_rs, d_rt                 source registers of the instruction in D
//   d_tuse_rs, d_tuse_rt       cycles until D needs each source (3 = not used)
//   d_we, d_wa, d_tnew         GPR write info of the D instruction (Tnew as it enters E)
//   stall, pc_en, d_en, e_clr  pipeline hold / bubble controls
//   fwd_rs_sel, fwd_rt_sel     D-stage operand source: 0 GPR, 1 E, 2 M, 3 W
//   stall_cnt                  saturating count of stalled cycles since reset
module stall_ctrl #(
    parameter int CNT_W      = 32,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_we,
    input  logic [4:0]       d_wa,
    input  logic [1:0]       d_tnew,
    output logic             stall,
    output logic             pc_en,
    output logic             d_en,
    output logic             e_clr,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] wa;
        logic [1:0] tnew;
    } slot_t;

    localparam logic [1:0] SEL_GPR = 2'd0;
    localparam logic [1:0] SEL_E   = 2'd1;
    localparam logic [1:0] SEL_M   = 2'd2;
    localparam logic [1:0] SEL_W   = 2'd3;

    slot_t slot_e, slot_m, slot_w;

    // Youngest producer of register r: {hit, stage code, remaining tnew}.
    function automatic logic [4:0] resolve(input logic [4:0] r, input slot_t se,
                                           input slot_t sm, input slot_t sw);
        logic ok;
        ok = !ZERO_GUARD || (r != 5'd0);
        if (ok && se.v && se.wa == r)
            return {1'b1, SEL_E, se.tnew};
        else if (ok && sm.v && sm.wa == r)
            return {1'b1, SEL_M, sm.tnew};
        else if (ok && sw.v && sw.wa == r)
            return {1'b1, SEL_W, sw.tnew};
        else
            return {1'b0, SEL_GPR, 2'd0};
    endfunction

    function automatic slot_t age(input slot_t s);
        slot_t o;
        o      = s;
        o.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
        return o;
    endfunction

    logic [4:0] rs_res, rt_res;
    logic       rs_haz, rt_haz;

    assign rs_res = resolve(d_rs, slot_e, slot_m, slot_w);
    assign rt_res = resolve(d_rt, slot_e, slot_m, slot_w);

    assign rs_haz = rs_res[4] && (rs_res[1:0] > d_tuse_rs);
    assign rt_haz = rt_res[4] && (rt_res[1:0] > d_tuse_rt);

    assign stall = rs_haz | rt_haz;
    assign pc_en = ~stall;
    assign d_en  = ~stall;
    assign e_clr = stall;

    // A ready producer is only forwarded when D actually advances this cycle.
    assign fwd_rs_sel = (!stall && rs_res[4] && rs_res[1:0] == 2'd0) ? rs_res[3:2] : SEL_GPR;
    assign fwd_rt_sel = (!stall && rt_res[4] && rt_res[1:0] == 2'd0) ? rt_res[3:2] : SEL_GPR;

    slot_t d_slot;
    always_comb begin
        d_slot      = '0;
        d_slot.v    = d_we && ((d_wa != 5'd0) || !ZERO_GUARD);
        d_slot.wa   = d_wa;
        d_slot.tnew = d_tnew;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_e    <= '0;
            slot_m    <= '0;
            slot_w    <= '0;
            stall_cnt <= '0;
        end else begin
            slot_w <= age(slot_m);
            slot_m <= age(slot_e);
            slot_e <= stall ? slot_t'(0) : d_slot;
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - table-driven scoreboard bench for stall_ctrl
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  d_rs, d_rt, d_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_we;

    logic        stall, pc_en, d_en, e_clr;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;

    logic        s_stall, s_pc_en, s_d_en, s_e_clr;
    logic [1:0]  s_fwd_rs_sel, s_fwd_rt_sel;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    stall_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_wa(d_wa), .d_tnew(d_tnew),
        .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
    );

    stall_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_wa(d_wa), .d_tnew(d_tnew),
        .stall(s_stall), .pc_en(s_pc_en), .d_en(s_d_en), .e_clr(s_e_clr),
        .fwd_rs_sel(s_fwd_rs_sel), .fwd_rt_sel(s_fwd_rt_sel), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] tr, tt;
        logic       we;
        logic [4:0] wa;
        logic [1:0] tn;
        logic       st;
        logic [1:0] fs, ft;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cnt_model = 0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [1:0] tr, input logic [1:0] tt,
                                input logic we, input logic [4:0] wa, input logic [1:0] tn,
                                input logic st, input logic [1:0] fs, input logic [1:0] ft,
                                input string tag);
        vec_t v;
        v.rs = rs; v.rt = rt; v.tr = tr; v.tt = tt; v.we = we; v.wa = wa; v.tn = tn;
        v.st = st; v.fs = fs; v.ft = ft; v.tag = tag;
        return v;
    endfunction

    function automatic vec_t nop(input string tag);
        return mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, tag);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_rt = v.rt; d_tuse_rs = v.tr; d_tuse_rt = v.tt;
        d_we = v.we; d_wa = v.wa; d_tnew = v.tn;
    endtask

    task automatic check_outputs(input vec_t e);
        chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
        chk({e.tag, ".pc_en"}, 32'(pc_en), 32'(!e.st));
        chk({e.tag, ".d_en"}, 32'(d_en), 32'(!e.st));
        chk({e.tag, ".e_clr"}, 32'(e_clr), 32'(e.st));
        chk({e.tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(e.fs));
        chk({e.tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(e.ft));
        chk({e.tag, ".cnt"}, stall_cnt, 32'(cnt_model));
        chk({e.tag, ".cnt_sat"}, 32'(s_stall_cnt), 32'((cnt_model > 3) ? 3 : cnt_model));
    endtask

    initial begin
        // lw $1 then add $2,$1,$3: one stall, then M slot tnew=1 is fine for tuse 1
        vecs.push_back(mk(2, 0, 1, 3, 1, 1, 2, 0, 0, 0, "a_lw"));
        vecs.push_back(mk(1, 3, 1, 1, 1, 2, 1, 1, 0, 0, "a_add_st"));
        vecs.push_back(mk(1, 3, 1, 1, 1, 2, 1, 0, 0, 0, "a_add_go"));
        repeat (3) vecs.push_back(nop("a_nop"));
        // lw $1 then beq $1,$0: two stalls, then forward from W
        vecs.push_back(mk(2, 0, 1, 3, 1, 1, 2, 0, 0, 0, "b_lw"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "b_beq_st1"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "b_beq_st2"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, "b_beq_go"));
        vecs.push_back(nop("b_nop"));
        // addu $4 then beq $4: one stall, forward from M; then rs==rt from W
        vecs.push_back(mk(5, 6, 1, 1, 1, 4, 1, 0, 0, 0, "c_addu"));
        vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, "c_beq_st"));
        vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 2, 0, "c_beq_go"));
        vecs.push_back(mk(4, 4, 1, 1, 1, 7, 1, 0, 3, 3, "c_rs_eq_rt"));
        repeat (3) vecs.push_back(nop("c_nop"));
        // addu $4 then addu $5,$4: no stall, no forward yet (tnew 1)
        vecs.push_back(mk(5, 6, 1, 1, 1, 4, 1, 0, 0, 0, "c_addu2"));
        vecs.push_back(mk(4, 6, 1, 1, 1, 5, 1, 0, 0, 0, "c_addu_dep"));
        repeat (3) vecs.push_back(nop("c_nop2"));
        // lw $0 then add $2,$0,$0: register 0 never hazards or forwards
        vecs.push_back(mk(2, 0, 1, 3, 1, 0, 2, 0, 0, 0, "d_lw0"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 2, 1, 0, 0, 0, "d_add0"));
        repeat (3) vecs.push_back(nop("d_nop"));
        // addu $6 / ori $6 / beq $6: youngest (E) wins, no forward from M
        vecs.push_back(mk(1, 2, 1, 1, 1, 6, 1, 0, 0, 0, "e_addu"));
        vecs.push_back(mk(7, 6, 1, 3, 1, 6, 1, 0, 0, 0, "e_ori"));
        vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 1, 0, 0, "e_beq_st"));
        vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 2, 0, "e_beq_go"));
        repeat (2) vecs.push_back(nop("e_nop"));
        // tuse 3 never stalls even behind a load
        vecs.push_back(mk(2, 0, 1, 3, 1, 3, 2, 0, 0, 0, "f_lw"));
        vecs.push_back(mk(3, 3, 3, 3, 0, 0, 0, 0, 0, 0, "f_unused"));
        repeat (3) vecs.push_back(nop("f_nop"));

        rst_n = 1'b0;
        drive(nop("rst"));
        repeat (2) @(posedge clk);
        #1;
        check_outputs(nop("reset"));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty at %0d", i);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check_outputs(e);
                if (e.st) cnt_model++;
            end
        end

        // Reset asserted in the middle of a load-use stall
        @(posedge clk); #1;
        drive(mk(2, 0, 1, 3, 1, 1, 2, 0, 0, 0, "g_lw"));
        @(negedge clk);
        check_outputs(mk(2, 0, 1, 3, 1, 1, 2, 0, 0, 0, "g_lw"));
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "g_beq"));
        @(negedge clk);
        check_outputs(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "g_beq_st"));
        #2;
        rst_n = 1'b0;
        cnt_model = 0;
        #1;
        check_outputs(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "g_in_reset"));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "g_after_reset"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
